// File: rtl/seq_alu.sv
// seq_alu: handshaked integer ALU for the execute stage.
// Basic ops finish in one cycle. The optional RV32M-style multiply/divide
// ops iterate one bit per cycle through a shift/accumulate datapath.
//
// Build option: define SEQ_ALU_MD_EN to include multiply/divide. Without it,
// codes 08-0F behave as undefined ops (result 0, 1-cycle latency) and busy
// is tied low.
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   in_valid   operands/mode valid       in_ready   accepting (IDLE)
//   a, b       operands (WordSize)       alu_mode   5-bit operation code
//   out_valid  alu_out holds a result    out_ready  consumer takes result
//   alu_out    registered result         busy       iterating (CALC)
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// CALC  | iterating a multiply/divide, one bit per cycle
// DONE  | result held on alu_out until out_ready
module seq_alu #(
    parameter int WordSize  = 32,
    parameter int ShAmtBits = $clog2(WordSize)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WordSize-1:0] a,
    input  logic [WordSize-1:0] b,
    input  logic [4:0]          alu_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WordSize-1:0] alu_out,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

    state_e                state_q, state_d;
    logic [WordSize-1:0]   alu_out_q, alu_out_d;
    logic [WordSize-1:0]   basic_res;
    logic [ShAmtBits-1:0]  shamt;

    assign shamt = b[ShAmtBits-1:0];

    always_comb begin
        basic_res = '0;
        case (alu_mode)
            5'h00: basic_res = a + b;
            5'h10: basic_res = a - b;
            5'h04: basic_res = a ^ b;
            5'h06: basic_res = a | b;
            5'h07: basic_res = a & b;
            5'h01: basic_res = a << shamt;
            5'h05: basic_res = a >> shamt;
            5'h15: basic_res = $unsigned($signed(a) >>> shamt);
            5'h02: basic_res = {{(WordSize-1){1'b0}}, ($signed(a) < $signed(b))};
            5'h03: basic_res = {{(WordSize-1){1'b0}}, (a < b)};
            default: basic_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MD_EN
    logic [ShAmtBits-1:0]  cnt_q, cnt_d;
    // hi: product high half / partial remainder; lo: multiplier / quotient
    logic [WordSize-1:0]   hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
    logic [2:0]            op_q, op_d;
    logic                  neg_q, neg_d;

    logic                  md_op, a_sgn, b_sgn, a_neg, b_neg, neg_acc;
    logic [WordSize-1:0]   a_mag, b_mag;
    logic [WordSize:0]     mul_sum, div_sh;
    logic                  div_ge;
    logic [WordSize-1:0]   step_hi, step_lo, div_val;
    logic [2*WordSize-1:0] prod, prod_s;
    logic [WordSize-1:0]   md_res;

    assign md_op = (alu_mode[4:3] == 2'b01);

    always_comb begin
        if (alu_mode[2]) begin
            a_sgn = ~alu_mode[0];
            b_sgn = ~alu_mode[0];
        end else begin
            // MUL low word is sign-agnostic; MULHSU treats only a as signed
            a_sgn = (alu_mode[1:0] == 2'b01) || (alu_mode[1:0] == 2'b10);
            b_sgn = (alu_mode[1:0] == 2'b01);
        end
        a_neg = a_sgn & a[WordSize-1];
        b_neg = b_sgn & b[WordSize-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        if (!alu_mode[2])
            neg_acc = a_neg ^ b_neg;
        else if (alu_mode[1])
            neg_acc = a_neg;
        else
            // divide by zero must stay all ones, so no quotient negation
            neg_acc = (a_neg ^ b_neg) && (b != '0);
    end

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        div_sh  = {hi_q, lo_q[WordSize-1]};
        div_ge  = (div_sh >= {1'b0, dvs_q});
        if (op_q[2]) begin
            step_hi = div_ge ? (div_sh[WordSize-1:0] - dvs_q) : div_sh[WordSize-1:0];
            step_lo = {lo_q[WordSize-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WordSize:1];
            step_lo = {mul_sum[0], lo_q[WordSize-1:1]};
        end
        prod    = {step_hi, step_lo};
        prod_s  = neg_q ? -prod : prod;
        div_val = op_q[1] ? step_hi : step_lo;
        if (op_q[2])
            md_res = neg_q ? -div_val : div_val;
        else if (op_q[1:0] == 2'b00)
            md_res = prod_s[WordSize-1:0];
        else
            md_res = prod_s[2*WordSize-1:WordSize];
    end
`endif

    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
`ifdef SEQ_ALU_MD_EN
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        dvs_d = dvs_q;
        op_d  = op_q;
        neg_d = neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef SEQ_ALU_MD_EN
                    if (md_op) begin
                        state_d = CALC;
                        cnt_d   = ShAmtBits'(WordSize - 1);
                        hi_d    = '0;
                        lo_d    = a_mag;
                        dvs_d   = b_mag;
                        op_d    = alu_mode[2:0];
                        neg_d   = neg_acc;
                    end else
`endif
                    begin
                        state_d   = DONE;
                        alu_out_d = basic_res;
                    end
                end
            end
`ifdef SEQ_ALU_MD_EN
            CALC: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == '0) begin
                    // last iteration and sign fix-up share this edge
                    state_d   = DONE;
                    alu_out_d = md_res;
                end else begin
                    cnt_d = cnt_q - ShAmtBits'(1);
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            alu_out_q <= '0;
`ifdef SEQ_ALU_MD_EN
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dvs_q <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
`ifdef SEQ_ALU_MD_EN
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            dvs_q <= dvs_d;
            op_q  <= op_d;
            neg_q <= neg_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign alu_out   = alu_out_q;
`ifdef SEQ_ALU_MD_EN
    assign busy = (state_q == CALC);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed vectors, scoreboard queue checked by a
// monitor on each rising out_valid (result value and latency).
module tb_seq_alu;

    localparam int W = 32;
`ifdef SEQ_ALU_MD_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int MLAT = MD ? W + 1 : 1;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [4:0]   alu_mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] alu_out;
    logic         busy;

    seq_alu #(.WordSize(W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_mode(alu_mode), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] val;
        int           acc;
        int           lat;
        string        name;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check32(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // monitor: compare on every rising out_valid
    logic prev_ov = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (!rstn) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got=%h expected none", alu_out);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check32(e.name, alu_out, e.val);
                    check_int({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic issue(input logic [4:0] mode, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] exp, input int lat, input string name, input bit push);
        int n;
        @(negedge clk);
        alu_mode = mode;
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: in_ready=%b expected 1", name, in_ready);
            in_valid = 1'b0;
        end else begin
            if (push) sbq.push_back('{exp, cyc + 1, lat, name});
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || !in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: pending=%0d in_ready=%b expected 0/1", name, sbq.size(), in_ready);
        end
    endtask

    function automatic logic [W-1:0] mdv(input logic [W-1:0] v);
        return MD ? v : '0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        logic [W-1:0] bp_exp;

        repeat (3) @(negedge clk);
        check32("rst_alu_out", alu_out, '0);
        check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rstn = 1'b1;

        issue(5'h00, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1, "add_ovf", 1'b1);
        issue(5'h02, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, "sslt", 1'b1);
        issue(5'h03, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, "uslt", 1'b1);
        issue(5'h15, 32'h8000_0000, 32'h24, 32'hF800_0000, 1, "ars", 1'b1);
        issue(5'h01, 32'h8000_0000, 32'h24, 32'h0, 1, "lls", 1'b1);
        issue(5'h05, 32'h8000_0000, 32'h24, 32'h0800_0000, 1, "lrs", 1'b1);
        issue(5'h10, 32'd5, 32'd3, 32'd2, 1, "sub", 1'b1);
        issue(5'h04, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, "xor", 1'b1);
        issue(5'h06, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1, "or", 1'b1);
        issue(5'h07, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, "and", 1'b1);
        issue(5'h1F, 32'd9, 32'd9, 32'd0, 1, "undef", 1'b1);
        wait_idle("basic");

        issue(5'h09, 32'hFFFF_FFFE, 32'd3, mdv(32'hFFFF_FFFF), MLAT, "mulh", 1'b1);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bc++;
            @(negedge clk);
        end
        check_int("mulh_busy_cycles", bc, MD ? W : 0);
        wait_idle("mulh");

        issue(5'h08, 32'hFFFF_FFFE, 32'd3, mdv(32'hFFFF_FFFA), MLAT, "mul", 1'b1);
        issue(5'h0B, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mdv(32'hFFFF_FFFE), MLAT, "mulhu", 1'b1);
        issue(5'h0A, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mdv(32'hFFFF_FFFF), MLAT, "mulhsu", 1'b1);
        issue(5'h0C, 32'hFFFF_FFF9, 32'd2, mdv(32'hFFFF_FFFD), MLAT, "div_neg", 1'b1);
        issue(5'h0E, 32'hFFFF_FFF9, 32'd2, mdv(32'hFFFF_FFFF), MLAT, "rem_neg", 1'b1);
        issue(5'h0C, 32'h8000_0000, 32'hFFFF_FFFF, mdv(32'h8000_0000), MLAT, "div_ovf", 1'b1);
        issue(5'h0E, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, MLAT, "rem_ovf", 1'b1);
        issue(5'h0D, 32'd7, 32'd0, mdv(32'hFFFF_FFFF), MLAT, "divu_zero", 1'b1);
        issue(5'h0F, 32'd7, 32'd0, mdv(32'd7), MLAT, "remu_zero", 1'b1);
        wait_idle("mdiv");

        // backpressure
        out_ready = 1'b0;
        bp_exp = mdv(32'd14);
        issue(5'h0C, 32'd100, 32'd7, bp_exp, MLAT, "div_bp", 1'b1);
        bc = 0;
        while (!out_valid && bc < 100) begin
            @(negedge clk);
            bc++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                alu_mode = 5'h00;
                a        = 32'd1;
                b        = 32'd1;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check32("bp_alu_out", alu_out, bp_exp);
            check32("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check32("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check32("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check32("bp_release_alu_out", alu_out, bp_exp);
        wait_idle("bp");

        // reset in the middle of a multiply
        issue(5'h08, 32'd5, 32'd6, 32'd0, 1, "mul_rst", !MD);
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        check32("midrst_alu_out", alu_out, '0);
        check32("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check32("midrst_busy", {31'd0, busy}, 32'd0);
        check32("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        issue(5'h00, 32'd2, 32'd3, 32'd5, 1, "add_after_rst", 1'b1);
        wait_idle("final");
        repeat (40) @(negedge clk);
        check_int("scoreboard_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle integer ALU.
- Registers every result behind a valid/ready interface and adds iterative RV32M-style multiply/divide modes (radix-2, one bit per cycle).
- Sits in the execute stage; the stage stalls on in_ready/out_valid instead of assuming single-cycle completion.

Parameters:
- WordSize, 32, operand/result width; must be a power of two and at least 8.
- ShAmtBits, $clog2(WordSize), number of b LSBs used as the shift amount (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept an operation.
- a  in  WordSize  operand A (rs1).
- b  in  WordSize  operand B (rs2/imm).
- alu_mode  in  5  operation code.
- out_valid  out  1  alu_out holds a finished result.
- out_ready  in  1  consumer takes the result.
- alu_out  out  WordSize  registered result.
- busy  out  1  high in CALC.

Behaviour:
- Basic modes (unchanged encodings):
  - ADD=00, SUB=10, XOR=04, OR=06, AND=07.
  - LLS=01, LRS=05, ARS=15; shift amount is b[ShAmtBits-1:0].
  - SSLT=02 (signed compare), USLT=03 (unsigned compare).
  - Any undefined code yields 0.
- M modes:
  - MUL=08: low word of a*b.
  - MULH=09: high word, signed x signed.
  - MULHSU=0A: high word, signed a x unsigned b.
  - MULHU=0B: high word, unsigned x unsigned.
  - DIV=0C, DIVU=0D, REM=0E, REMU=0F.
  - Arithmetic is two's complement, and every result is truncated to WordSize.
- FSM states: IDLE, CALC, DONE.
  - Reset: state=IDLE, alu_out=0, out_valid=0, busy=0, all internal accumulators and counters = 0. Reset takes effect immediately in any state. An in-flight operation is discarded and no result is produced.
  - in_ready = (state==IDLE). An operation is accepted on the edge where in_valid & in_ready; a, b and alu_mode are captured at that edge.
  - Basic mode: IDLE->DONE. out_valid is high the cycle after acceptance (1-cycle latency).
  - M mode: IDLE->CALC. The counter is loaded with WordSize-1 and decrements each cycle. At 0 the FSM goes CALC->DONE. out_valid rises exactly WordSize+1 cycles after acceptance (33 for WordSize=32).
  - Signed ops take operand magnitudes at accept; the sign is fixed up on the CALC->DONE edge with no extra cycle.
  - DONE: alu_out and out_valid are held stable while out_ready=0. On out_ready=1, DONE->IDLE; out_valid drops next cycle and alu_out holds its last value.
  - Throughput: one basic op per 2 cycles. No new op is accepted in the same cycle a result is taken.
  - in_valid while not IDLE is ignored (no capture, no error).
- Divide-by-zero (b=0):
  - DIV/DIVU return all ones; REM/REMU return a.
  - Full WordSize+1 latency still applies.
- Signed overflow (DIV/REM with a = most-negative, b = -1): DIV returns the most-negative value, REM returns 0.
- Compare modes return 0 or 1, zero-extended.

Optional Feature:
- Macro: SEQ_ALU_MD_EN.
- Defined: M modes behave as above; CALC state, counter and shift/accumulate datapath are present.
- Undefined: CALC and all multiply/divide logic are removed. Modes 08-0F are treated as undefined (result 0, 1-cycle latency), and busy is tied to 0.

Test Plan:
- Reset, then ADD a=32'h7FFF_FFFF b=1 with out_ready=1 -> out_valid 1 cycle after accept, alu_out=32'h8000_0000; SSLT a=-1 b=1 -> 1; USLT a=-1 b=1 -> 0.
- ARS a=32'h8000_0000 b=32'h0000_0024 (shift 4) -> 32'hF800_0000; LLS with same b -> 0.
- MULH a=-2 b=3 -> 32'hFFFF_FFFF after exactly 33 cycles; MUL same operands -> 32'hFFFF_FFFA; busy high for 32 cycles.
- DIV a=32'h8000_0000 b=-1 -> 32'h8000_0000; REM same -> 0; DIVU a=7 b=0 -> 32'hFFFF_FFFF; REMU a=7 b=0 -> 7.
- Backpressure: hold out_ready=0 for 5 cycles after DIV 100/7 -> alu_out=14 stable, in_ready=0 throughout; pulse in_valid with new operands meanwhile -> ignored.
- Deassert rstn at cycle 10 of a MUL -> outputs 0 immediately; after release, a fresh ADD 2+3 returns 5 with no stale result.
